// File: rtl/serial_pkg.sv
// serial_pkg
// Shared definitions for the serial link blocks (receiver and transmitter):
// the receive/transmit FSM state encoding and the default word and gap sizes.
package serial_pkg;

    // Default number of bits per word.
    localparam int SERIAL_WIDTH_DEFAULT   = 8;
    // Default number of consecutive mid-word idle cycles that abort a word.
    localparam int SERIAL_GAP_MAX_DEFAULT = 4;

    // S_IDLE: no partial word held. S_RECV: at least one bit captured.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } serial_state_e;

endpackage

// File: rtl/serial2parallel_if.sv
// serial2parallel_if
// Bundles the serial input side, the word output handshake and the status
// flags of the serial-to-parallel receiver.
//   master : the environment (drives serial_in/in_valid/out_ready/clear_err)
//   slave  : the receiver (drives data_out/out_valid/overrun/frame_err/busy)
interface serial2parallel_if #(
    parameter int WIDTH = 8
);
    logic             serial_in;
    logic             in_valid;
    logic             out_ready;
    logic             clear_err;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             overrun;
    logic             frame_err;
    logic             busy;

    modport master (
        output serial_in, in_valid, out_ready, clear_err,
        input  data_out, out_valid, overrun, frame_err, busy
    );

    modport slave (
        input  serial_in, in_valid, out_ready, clear_err,
        output data_out, out_valid, overrun, frame_err, busy
    );
endinterface

// File: rtl/s2p_out_buf.sv
// s2p_out_buf
// Single-entry holding register for completed words with a valid/ready
// handshake and a sticky overrun flag.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load, word : a completed word is offered this cycle
//   out_ready  : downstream consumes data_out when out_valid is high
//   clear_err  : clears the overrun flag (a same-edge overrun wins)
//   data_out, out_valid, overrun : registered outputs
module s2p_out_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             out_ready,
    input  logic             clear_err,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             overrun
);
    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;
    logic             overrun_reg;

    logic consume;
    logic accept;
    logic drop;

    assign consume = valid_reg & out_ready;
    // A new word fits if the register is empty or is emptied on this edge,
    // which gives back-to-back words without a bubble.
    assign accept  = load & (~valid_reg | out_ready);
    // Otherwise the new word is lost and the old one is kept.
    assign drop    = load & valid_reg & ~out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (accept) begin
                data_reg <= word;
            end

            if (accept) begin
                valid_reg <= 1'b1;
            end else if (consume) begin
                valid_reg <= 1'b0;
            end

            if (drop) begin
                overrun_reg <= 1'b1;
            end else if (clear_err) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign data_out  = data_reg;
    assign out_valid = valid_reg;
    assign overrun   = overrun_reg;
endmodule

// File: rtl/serial2parallel.sv
// serial2parallel
// Assembles LSB-first serial bits into WIDTH-bit words. A partial word is
// abandoned (with a one-cycle frame_err pulse) after GAP_MAX consecutive idle
// cycles; completed words go to the s2p_out_buf holding register.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : serial2parallel_if.slave
//              in : serial_in, in_valid, out_ready, clear_err
//              out: data_out, out_valid, overrun, frame_err, busy
module serial2parallel
    import serial_pkg::*;
#(
    parameter int WIDTH   = SERIAL_WIDTH_DEFAULT,
    parameter int GAP_MAX = SERIAL_GAP_MAX_DEFAULT
) (
    input logic              clk,
    input logic              rst,
    serial2parallel_if.slave bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int GW = $clog2(GAP_MAX) + 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_MAX - 1);

    serial_state_e    state_reg;
    serial_state_e    state_next;
    logic [WIDTH-1:0] shifter_reg;
    logic [BW-1:0]    bit_cnt_reg;
    logic [GW-1:0]    gap_cnt_reg;
    logic             frame_err_reg;
    logic             busy_comb;

    logic [WIDTH-1:0] shifted;
    logic             word_done;
    logic             timeout;
    logic [WIDTH-1:0] buf_data;
    logic             buf_valid;
    logic             buf_overrun;

    assign shifted   = {bus.serial_in, shifter_reg[WIDTH-1:1]};
    // bit_cnt is 0 in IDLE and WIDTH >= 2, so this can only fire in RECV.
    assign word_done = bus.in_valid && (bit_cnt_reg == BIT_LAST);
    // The gap counter has already seen GAP_MAX-1 idle cycles; one more aborts.
    assign timeout   = (state_reg == S_RECV) && !bus.in_valid && (gap_cnt_reg == GAP_LAST);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (bus.in_valid)          state_next = S_RECV;
            S_RECV: if (word_done || timeout)  state_next = S_IDLE;
            default:                           state_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_comb = (state_reg == S_RECV);
    end

    // Shifter and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            shifter_reg   <= '0;
            bit_cnt_reg   <= '0;
            gap_cnt_reg   <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= timeout;
            if (bus.in_valid) begin
                shifter_reg <= shifted;
                bit_cnt_reg <= word_done ? '0 : bit_cnt_reg + BW'(1);
                gap_cnt_reg <= '0;
            end else if (timeout) begin
                shifter_reg <= '0;
                bit_cnt_reg <= '0;
                gap_cnt_reg <= '0;
            end else if (state_reg == S_RECV) begin
                gap_cnt_reg <= gap_cnt_reg + GW'(1);
            end
        end
    end

    s2p_out_buf #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (word_done),
        .word     (shifted),
        .out_ready(bus.out_ready),
        .clear_err(bus.clear_err),
        .data_out (buf_data),
        .out_valid(buf_valid),
        .overrun  (buf_overrun)
    );

    assign bus.data_out  = buf_data;
    assign bus.out_valid = buf_valid;
    assign bus.overrun   = buf_overrun;
    assign bus.frame_err = frame_err_reg;
    assign bus.busy      = busy_comb;
endmodule

// File: tb/tb_serial2parallel.sv
// tb_serial2parallel
// Directed scenarios plus a randomized run for serial2parallel (WIDTH=8,
// GAP_MAX=4), compared against a bit-queue reference model.
module tb_serial2parallel;
    localparam int WIDTH   = 8;
    localparam int GAP_MAX = 4;

    logic clk = 1'b0;
    logic rst;

    serial2parallel_if #(.WIDTH(WIDTH)) bus_if();

    serial2parallel #(
        .WIDTH  (WIDTH),
        .GAP_MAX(GAP_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: collected bits of the current word, idle run length,
    // and the expected visible outputs.
    bit         m_bits[$];
    int         m_gap   = 0;
    logic [7:0] m_data  = '0;
    logic       m_valid = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_ferr  = 1'b0;

    function automatic logic [11:0] obs();
        return {bus_if.data_out, bus_if.out_valid, bus_if.overrun, bus_if.frame_err, bus_if.busy};
    endfunction

    function automatic logic [11:0] expv();
        return {m_data, m_valid, m_ovr, m_ferr, (m_bits.size() != 0)};
    endfunction

    // Drive one cycle, advance the model on the edge, sample 1 time unit later.
    task automatic step(input logic s, input logic v, input logic r, input logic c, input logic rs);
        logic [7:0] w;
        logic       done;
        logic       consume;
        bus_if.serial_in = s;
        bus_if.in_valid  = v;
        bus_if.out_ready = r;
        bus_if.clear_err = c;
        rst              = rs;
        @(posedge clk);
        cyc++;
        if (rs) begin
            m_bits.delete();
            m_gap   = 0;
            m_data  = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_ferr  = 1'b0;
        end else begin
            done    = 1'b0;
            w       = '0;
            consume = m_valid && r;
            m_ferr  = 1'b0;
            if (v) begin
                m_bits.push_back(s);
                m_gap = 0;
                if (m_bits.size() == WIDTH) begin
                    for (int i = 0; i < WIDTH; i++) w[i] = m_bits[i];
                    m_bits.delete();
                    done = 1'b1;
                end
            end else if (m_bits.size() != 0) begin
                m_gap++;
                if (m_gap == GAP_MAX) begin
                    m_bits.delete();
                    m_gap  = 0;
                    m_ferr = 1'b1;
                end
            end
            if (done && m_valid && !consume) m_ovr = 1'b1;
            else if (c)                      m_ovr = 1'b0;
            if (done && (!m_valid || consume)) begin
                m_data  = w;
                m_valid = 1'b1;
            end else if (consume) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (obs() !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state cyc %0d: got %h expected 000", cyc, obs());
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL reset_release cyc %0d: got %h expected %h", cyc, obs(), expv());
        end
    endtask

    task automatic test_contiguous();
        logic [7:0] w = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            step(w[i], 1'b1, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL contig_bit%0d cyc %0d: got %h expected %h", i, cyc, obs(), expv());
            end
        end
        n_checks++;
        if (bus_if.data_out !== 8'hA5 || bus_if.out_valid !== 1'b1 || bus_if.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL contig_word: got data=%h v=%b o=%b expected data=a5 v=1 o=0",
                     bus_if.data_out, bus_if.out_valid, bus_if.overrun);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL contig_consumed: got out_valid=%b expected 0", bus_if.out_valid);
        end
    endtask

    task automatic test_tolerated_gap();
        logic [7:0] w = 8'hA5;
        logic       ferr_seen = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i < 4)       step(w[i],     1'b1, 1'b1, 1'b0, 1'b0);
            else if (i < 7)  step(1'b1,     1'b0, 1'b1, 1'b0, 1'b0);
            else             step(w[i - 3], 1'b1, 1'b1, 1'b0, 1'b0);
            ferr_seen |= bus_if.frame_err;
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL gap_ok_step%0d cyc %0d: got %h expected %h", i, cyc, obs(), expv());
            end
        end
        n_checks++;
        if (bus_if.data_out !== 8'hA5 || bus_if.out_valid !== 1'b1 || ferr_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_ok_word: got data=%h v=%b ferr_seen=%b expected data=a5 v=1 ferr_seen=0",
                     bus_if.data_out, bus_if.out_valid, ferr_seen);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_gap_timeout();
        logic [7:0] w = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            else       step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL timeout_step%0d cyc %0d: got %h expected %h", i, cyc, obs(), expv());
            end
            if (i == 6) begin
                n_checks++;
                if (bus_if.busy !== 1'b1 || bus_if.frame_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_early: got busy=%b ferr=%b expected busy=1 ferr=0",
                             bus_if.busy, bus_if.frame_err);
                end
            end
        end
        n_checks++;
        if (bus_if.frame_err !== 1'b1 || bus_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: got ferr=%b busy=%b expected ferr=1 busy=0",
                     bus_if.frame_err, bus_if.busy);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus_if.frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_one_cycle: got ferr=%b expected 0", bus_if.frame_err);
        end
        for (int i = 0; i < 8; i++) step(w[i], 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus_if.data_out !== 8'h3C || bus_if.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_next_word: got data=%h v=%b expected data=3c v=1",
                     bus_if.data_out, bus_if.out_valid);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_overrun();
        logic [7:0] w1 = 8'h11;
        logic [7:0] w2 = 8'h22;
        for (int i = 0; i < 8; i++) step(w1[i], 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus_if.data_out !== 8'h11 || bus_if.out_valid !== 1'b1 || bus_if.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_first: got data=%h v=%b o=%b expected data=11 v=1 o=0",
                     bus_if.data_out, bus_if.out_valid, bus_if.overrun);
        end
        for (int i = 0; i < 8; i++) begin
            step(w2[i], 1'b1, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL ovr_bit%0d cyc %0d: got %h expected %h", i, cyc, obs(), expv());
            end
        end
        n_checks++;
        if (bus_if.data_out !== 8'h11 || bus_if.overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set: got data=%h o=%b expected data=11 o=1",
                     bus_if.data_out, bus_if.overrun);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (bus_if.overrun !== 1'b0 || bus_if.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_clear: got o=%b v=%b expected o=0 v=1", bus_if.overrun, bus_if.out_valid);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_drain: got v=%b expected 0", bus_if.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w1 = 8'h01;
        logic [7:0] w2 = 8'h02;
        for (int i = 0; i < 8; i++) step(w1[i], 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus_if.data_out !== 8'h01 || bus_if.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got data=%h v=%b expected data=01 v=1",
                     bus_if.data_out, bus_if.out_valid);
        end
        // Hold the first word until the second completes, then consume and
        // load on the same edge.
        for (int i = 0; i < 8; i++) begin
            step(w2[i], 1'b1, (i == 7), 1'b0, 1'b0);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL b2b_bit%0d cyc %0d: got %h expected %h", i, cyc, obs(), expv());
            end
        end
        n_checks++;
        if (bus_if.data_out !== 8'h02 || bus_if.out_valid !== 1'b1 || bus_if.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: got data=%h v=%b o=%b expected data=02 v=1 o=0",
                     bus_if.data_out, bus_if.out_valid, bus_if.overrun);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w = 8'h5A;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (obs() !== 12'h000) begin
            n_fail++;
            $display("FAIL rst_mid_state cyc %0d: got %h expected 000", cyc, obs());
        end
        for (int i = 0; i < 8; i++) step(w[i], 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus_if.data_out !== 8'h5A || bus_if.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_word: got data=%h v=%b expected data=5a v=1",
                     bus_if.data_out, bus_if.out_valid);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int vpct;
        for (int i = 0; i < 1500; i++) begin
            case ((i / 100) % 3)
                0:       vpct = 90;
                1:       vpct = 60;
                default: vpct = 30;
            endcase
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < vpct),
                 ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 1));
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h expected %h", cyc, obs(), expv());
            end
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus_if.serial_in = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.clear_err = 1'b0;
        test_reset();
        test_contiguous();
        test_tolerated_gap();
        test_gap_timeout();
        test_overrun();
        test_back_to_back();
        test_reset_mid_word();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial2parallel.md
SERIAL2PARALLEL -- requirements
Module: serial2parallel

Interface
REQ-001 Parameter WIDTH, default 8, the number of bits per word; the legal range is at least 2.
REQ-002 Parameter GAP_MAX, default 4, the number of consecutive idle cycles mid-word that aborts the partial word; the legal range is at least 1.
REQ-003 clk  input  1  is the single clock; all logic SHALL act on its rising edge.
REQ-004 rst  input  1  is the reset, which is synchronous and active-high.
REQ-005 serial_in  input  1  carries one serial data bit, LSB first.
REQ-006 in_valid  input  1  qualifies serial_in; one bit SHALL be consumed per clk edge where in_valid=1.
REQ-007 out_ready  input  1  signals that downstream accepts data_out this cycle.
REQ-008 clear_err  input  1  clears the sticky overrun flag.
REQ-009 data_out  output  WIDTH  carries the assembled word; it SHALL be held stable while out_valid=1.
REQ-010 out_valid  output  1  indicates that the holding register contains an unconsumed word.
REQ-011 overrun  output  1  is a sticky flag: a word completed while the holding register was full and not being consumed.
REQ-012 frame_err  output  1  is a one-cycle pulse indicating that a partial word was discarded on a gap timeout.
REQ-013 busy  output  1  indicates that the FSM is in RECV.

Function
REQ-014 FSM states: IDLE means no partial word and bit_cnt=0; RECV means at least one bit of the current word has been captured.
REQ-015 IDLE with in_valid=1 SHALL capture the bit and move to RECV; with WIDTH bits this is the first of WIDTH bits.
REQ-016 Each capture: shifter <= {serial_in, shifter[WIDTH-1:1]}; bit_cnt increments; gap_cnt resets to 0.
REQ-017 Word completion: a capture with bit_cnt=WIDTH-1 SHALL complete the word. On completion:
- the word is {serial_in, shifter[WIDTH-1:1]};
- bit_cnt returns to 0;
- the FSM goes to IDLE.
REQ-018 Latency: out_valid SHALL be 1 and data_out SHALL equal the word on the cycle after the completing edge.
REQ-019 Handshake: the holding register is consumed on an edge where out_valid=1 and out_ready=1. out_valid SHALL then fall unless a new word loads on that same edge.
REQ-020 Completion with a consumption on the same edge SHALL load the new word, keep out_valid=1 and leave overrun unchanged. This allows back-to-back words with no bubble.
REQ-021 Completion with out_valid=1 and out_ready=0 SHALL:
- drop the new word;
- keep the old data_out;
- set overrun=1.
REQ-022 overrun SHALL stay 1 until clear_err=1 or rst. If clear_err and a new overrun event occur on the same edge, the set SHALL win.
REQ-023 Gap timeout, RECV with in_valid=0: gap_cnt increments. When gap_cnt reaches GAP_MAX-1 and in_valid=0 again:
- discard the partial word;
- pulse frame_err for one cycle;
- go to IDLE, with bit_cnt and gap_cnt returning to 0.
REQ-024 Gaps of up to GAP_MAX-1 cycles mid-word SHALL NOT alter the assembled word.
REQ-025 IDLE with in_valid=0 SHALL NOT count gap cycles and SHALL NOT raise frame_err.
REQ-026 A gap timeout SHALL NOT affect the holding register, out_valid or overrun.
REQ-027 The bit counter and gap counter SHALL be $clog2(WIDTH) and $clog2(GAP_MAX)+1 bits wide respectively. Neither SHALL wrap past its terminal value.

Reset
REQ-028 While rst=1 at an edge, the block SHALL drive the following, and discard any partial word:
- FSM state IDLE;
- shifter, bit_cnt and gap_cnt at 0;
- data_out 0, out_valid 0, overrun 0, frame_err 0, busy 0.
REQ-029 Reset SHALL take priority over every other input, including in_valid, out_ready and clear_err.
REQ-030 The first in_valid=1 edge after rst deasserts SHALL be treated as bit 0 of a new word.

Structure
REQ-031 A shared package serial_pkg SHALL hold the FSM state enum (S_IDLE, S_RECV) and the default WIDTH/GAP_MAX constants. The existing parallel-to-serial transmitter SHALL be able to import it.
REQ-032 Exactly one sub-module, s2p_out_buf, SHALL implement the holding register, the out_valid/out_ready handshake and the overrun logic. The top level SHALL hold the FSM, the shifter and the counters.

Verification
REQ-033 All scenarios SHALL use WIDTH=8 and GAP_MAX=4:
- Contiguous word: bits 1,0,1,0,0,1,0,1 on 8 consecutive edges, out_ready=1 -> out_valid=1 for one cycle after the 8th edge, data_out=0xA5, overrun=0.
- Tolerated gap: 0xA5 sent with a 3-cycle in_valid=0 gap after bit 3 -> data_out=0xA5, frame_err never asserted.
- Gap timeout: 4 bits, then a 4-cycle gap -> one frame_err pulse and busy falls; then send 0x3C -> data_out=0x3C.
- Overrun: out_ready=0, send 0x11 then 0x22 -> data_out stays 0x11, overrun=1; clear_err pulse -> overrun=0; out_ready=1 -> out_valid falls.
- Back-to-back: out_ready=1, 0x01 then 0x02 with no idle cycles -> two words in order, out_valid high across the boundary, overrun=0.
- Reset mid-word: 4 bits of 0xFF, then rst for 1 cycle -> all outputs 0; then send 0x5A -> data_out=0x5A.
